// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags. The FIFO sits on the slave side.
interface sync_fifo_flags_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact occupancy count, full/empty, programmable
// almost-full/almost-empty, sticky overflow/underflow and synchronous flush.
// FWFT=0 registers dout on each accepted read; FWFT=1 presents the head word.
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = 28,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_flags_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt  = (ADDR_WIDTH + 1)'(Depth);
  localparam logic [ADDR_WIDTH:0] AfullCnt  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AemptyCnt = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  // Out-of-range thresholds would give flags that never or always assert.
  if (AFULL_THRESH < 1 || AFULL_THRESH > Depth) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH > Depth - 1) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Flags come from the count register only; no path from wr_en/rd_en.
  assign w_full  = (r_count == DepthCnt);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = bus.wr_en & ~w_full  & ~bus.flush;
  assign w_rd_ok = bus.rd_en & ~w_empty & ~bus.flush;

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AfullCnt);
  assign bus.almost_empty = (r_count <= AemptyCnt);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - 1'b1;
      end
      if (bus.wr_en && w_full)  r_overflow  <= 1'b1;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  // Storage array; contents deliberately survive reset and flush.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= bus.din;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.dout = r_mem[r_rd_ptr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_dout;

    // Registered read port: holds its value unless a read is accepted.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dout <= '0;
      end else if (w_rd_ok) begin
        r_dout <= r_mem[r_rd_ptr];
      end
    end

    assign bus.dout = r_dout;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-mode and an FWFT instance share the
// same stimulus and are compared each cycle against a queue-based model.
module tb_sync_fifo_flags;
  localparam int Dw = 8;
  localparam int Aw = 5;
  localparam int Depth = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [Dw-1:0] din = '0;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state.
  logic [Dw-1:0] q[$];
  logic [Dw-1:0] m_dout = '0;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw)) bus0 ();
  sync_fifo_flags_if #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw)) bus1 ();

  assign bus0.flush = flush;
  assign bus0.wr_en = wr_en;
  assign bus0.rd_en = rd_en;
  assign bus0.din   = din;
  assign bus1.flush = flush;
  assign bus1.wr_en = wr_en;
  assign bus1.rd_en = rd_en;
  assign bus1.din   = din;

  sync_fifo_flags #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw), .FWFT(0)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sync_fifo_flags #(.DATA_WIDTH(Dw), .ADDR_WIDTH(Aw), .FWFT(1)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("std.count", 32'(bus0.count), n);
    check("std.full", 32'(bus0.full), 32'(n == Depth));
    check("std.empty", 32'(bus0.empty), 32'(n == 0));
    check("std.afull", 32'(bus0.almost_full), 32'(n >= 28));
    check("std.aempty", 32'(bus0.almost_empty), 32'(n <= 4));
    check("std.ovf", 32'(bus0.overflow), 32'(m_ovf));
    check("std.udf", 32'(bus0.underflow), 32'(m_udf));
    check("std.dout", 32'(bus0.dout), 32'(m_dout));
    check("fwft.count", 32'(bus1.count), n);
    check("fwft.empty", 32'(bus1.empty), 32'(n == 0));
    check("fwft.full", 32'(bus1.full), 32'(n == Depth));
    check("fwft.ovf", 32'(bus1.overflow), 32'(m_ovf));
    check("fwft.udf", 32'(bus1.underflow), 32'(m_udf));
    if (n != 0) check("fwft.dout", 32'(bus1.dout), 32'(q[0]));
  endtask

  // Model behaviour at one rising edge, from the pre-edge occupancy.
  task automatic model_edge(input bit w, input bit r, input bit f, input logic [Dw-1:0] d);
    int n;
    n = q.size();
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && n == Depth) m_ovf = 1'b1;
      if (r && n == 0) m_udf = 1'b1;
      if (r && n != 0) m_dout = q.pop_front();
      if (w && n != Depth) q.push_back(d);
    end
  endtask

  task automatic cycle(input bit w, input bit r, input bit f, input logic [Dw-1:0] d);
    wr_en = w;
    rd_en = r;
    flush = f;
    din   = d;
    @(posedge clk);
    model_edge(w, r, f, d);
    #1;
    check_all();
  endtask

  initial begin
    int wp;
    int rp;
    // Reset state with rst held.
    #2;
    check_all();
    check("rst.dout0", 32'(bus0.dout), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill to full, then one rejected write.
    for (int i = 0; i < Depth; i++) cycle(1, 0, 0, 8'(i));
    cycle(1, 0, 0, 8'hAA);
    check("fill.ovf", 32'(bus0.overflow), 32'h1);

    // Drain, then one rejected read.
    for (int i = 0; i < Depth; i++) cycle(0, 1, 0, 8'h00);
    check("drain.last", 32'(bus0.dout), 32'h1F);
    cycle(0, 1, 0, 8'h00);
    check("drain.udf_dout", 32'(bus0.dout), 32'h1F);

    // Simultaneous read/write across pointer wrap.
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) cycle(1, 1, 0, 8'($urandom));
    for (int i = 0; i < 22; i++) cycle(1, 0, 0, 8'($urandom));
    cycle(1, 1, 0, 8'hEE);
    check("simul.count31", 32'(bus0.count), 32'd31);

    // Flush at count 20 with overflow set; write in that cycle ignored.
    for (int i = 0; i < 11; i++) cycle(0, 1, 0, 8'h00);
    cycle(1, 0, 1, 8'h77);
    cycle(1, 0, 0, 8'h9A);
    cycle(0, 1, 0, 8'h00);
    check("flush.readback", 32'(bus0.dout), 32'h9A);

    // Asynchronous reset between edges during a write burst.
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 8'(8'h40 + i));
    wr_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    q.delete();
    m_dout = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_all();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 8'h55);
    cycle(0, 1, 0, 8'h00);
    check("rst.readback", 32'(bus0.dout), 32'h55);

    // First-word-fall-through presentation.
    cycle(1, 0, 0, 8'h3C);
    check("fwft.first", 32'(bus1.dout), 32'h3C);
    cycle(1, 0, 0, 8'h3D);
    cycle(0, 1, 0, 8'h00);
    check("fwft.next", 32'(bus1.dout), 32'h3D);
    check("fwft.cnt1", 32'(bus1.count), 32'd1);

    // Random traffic with drifting bias so both full and empty are visited.
    for (int i = 0; i < 2000; i++) begin
      if ((i / 100) % 2 == 0) begin
        wp = 75;
        rp = 35;
      end else begin
        wp = 35;
        rp = 75;
      end
      cycle(bit'($urandom_range(0, 99) < wp), bit'($urandom_range(0, 99) < rp),
            bit'($urandom_range(0, 63) == 0), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO buffer with an exact occupancy count, full/empty and programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. A synchronous flush empties the buffer. The FWFT parameter selects standard read-latency mode or first-word-fall-through mode. Intended as the general-purpose buffering block between producer and consumer stages in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word.
ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH (32 words by default).
FWFT, 0, 0 = standard mode (dout registered, 1-cycle read latency); 1 = first-word-fall-through.
AFULL_THRESH, 28, almost_full asserts when count >= this value; legal range 1..DEPTH.
AEMPTY_THRESH, 4, almost_empty asserts when count <= this value; legal range 0..DEPTH-1.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of pointers, count and error flags.
wr_en  in  1  write request.
din  in  DATA_WIDTH  write data.
rd_en  in  1  read request (acknowledge in FWFT mode).
dout  out  DATA_WIDTH  read data.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AFULL_THRESH.
almost_empty  out  1  count <= AEMPTY_THRESH.
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a write was attempted while full.
underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr=0, rd_ptr=0, count=0, dout=0, overflow=0, underflow=0. Flags follow count: empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- Write acceptance: wr_ok = wr_en & ~full & ~flush. On wr_ok, mem[wr_ptr]<=din and wr_ptr increments, wrapping from DEPTH-1 to 0.
- Read acceptance: rd_ok = rd_en & ~empty & ~flush. On rd_ok, rd_ptr increments with the same wrap rule.
- full and empty are evaluated on the registered count before the edge. A write while full is rejected even if a read is accepted in the same cycle.
- count update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither occur. count is never less than 0 and never greater than DEPTH.
- All flags are decoded from the count register only. They change on the same edge as count, with no combinational path from wr_en or rd_en.
- FWFT=0: on rd_ok, dout <= mem[rd_ptr] at that edge, so data appears 1 cycle after the request. Otherwise dout holds its last value, including when a read is rejected.
- FWFT=1: dout = mem[rd_ptr] continuously and is valid whenever empty=0. rd_ok pops the word and the next word is presented in the following cycle. dout value while empty=1 is unspecified and the bench must not check it.
- Write-to-read visibility: a word written at edge N gives empty=0 after edge N. It can be read from edge N+1.
- Error flags: overflow sets on (wr_en & full & ~flush). underflow sets on (rd_en & empty & ~flush). Both stay set until rst or flush. Rejected operations do not change pointers, count or memory.
- flush: at the next edge, pointers=0, count=0, overflow=0, underflow=0. wr_en and rd_en in that cycle are ignored. dout holds its value.
- Reset asserted mid-operation: all state returns to the reset values immediately. The first accepted write after rst deasserts lands at address 0.
- Illegal threshold parameters must be flagged by an elaboration-time check; they are not silently clamped.

Test Plan:
- Fill (defaults): write 0x00..0x1F on 32 consecutive cycles -> count steps 1..32; almost_empty falls when count=5; almost_full rises at 28; full=1 at 32; a 33rd write of 0xAA -> rejected, overflow=1, count stays 32.
- Drain, FWFT=0: rd_en for 32 cycles -> dout=0x00..0x1F, each 1 cycle after its request; empty=1 after the last read; a further rd_en -> underflow=1, dout stays 0x1F.
- Simultaneous: preload 10 words, then wr_en=rd_en=1 for 40 cycles -> count stays 10, data order is preserved across pointer wrap. At count=32 with wr_en=rd_en=1 -> read accepted, write rejected, count=31, overflow=1.
- Flush: at count=20 with overflow=1, pulse flush with wr_en=1 -> count=0, empty=1, overflow=0, the write is ignored; the next write lands at address 0 and reads back correctly.
- Reset mid-burst: assert rst asynchronously between edges during writes at count=7 -> outputs immediately read dout=0, count=0, empty=1, almost_empty=1, all other flags 0; then write 0x55, read back 0x55.
- FWFT=1 instance: write 0x3C to an empty FIFO -> after that edge empty=0 and dout=0x3C with no rd_en; write 0x3D, pulse rd_en -> dout=0x3D the next cycle, count=1.
